// File: rtl/frame_rate_divider_pkg.sv
`default_nettype none
// ============================================================================
// Package  : frame_pkg -- shared defaults, channel mode and bus slicing helper
// Revision : 1.0
// ============================================================================
package frame_pkg;

  localparam int FRAME_W        = 4;
  localparam int FRAME_CHANNELS = 2;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_t;

  // Low bit of channel ch within a flattened CHANNELS*WIDTH bus.
  function automatic int chan_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_rate_divider_if.sv
`default_nettype none
// ============================================================================
// Interface : frame_rate_divider_if -- frame divider control and status bus
// Revision  : 1.0
// ============================================================================
interface frame_rate_divider_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
);

  logic                      enable;
  logic [CHANNELS*WIDTH-1:0] speed;
  logic [CHANNELS-1:0]       oneshot;
  logic [CHANNELS-1:0]       restart;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       armed;

  modport master (
    output enable, speed, oneshot, restart,
    input  tick, count, armed
  );

  modport slave (
    input  enable, speed, oneshot, restart,
    output tick, count, armed
  );

endinterface
`default_nettype wire

// File: rtl/frame_rate_divider_channel.sv
`default_nettype none
// ============================================================================
// Module   : frame_div_channel -- one frame counter, armed flag, tick register
// Revision : 1.0
// ============================================================================
module frame_div_channel
  import frame_pkg::*;
#(
  parameter int WIDTH = FRAME_W
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  input  wire logic             i_enable,
  input  wire logic [WIDTH-1:0] i_speed,
  input  wire logic             i_oneshot,
  input  wire logic             i_restart,
  output logic                  o_tick,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_armed
);

  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_armed;
  mode_t            w_mode;

  assign w_mode = mode_t'(i_oneshot);

  // Terminal test is >= so a speed lowered below the count fires instead of wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_tick <= 1'b0;
      if (i_restart) begin
        r_count <= '0;
        r_armed <= 1'b1;
      end else if (r_armed && i_enable) begin
        if (r_count >= i_speed) begin
          r_count <= '0;
          r_tick  <= 1'b1;
          if (w_mode == MODE_ONESHOT) begin
            r_armed <= 1'b0;
          end
        end else begin
          r_count <= r_count + WIDTH'(1);
        end
      end
    end
  end

  assign o_tick  = r_tick;
  assign o_count = r_count;
  assign o_armed = r_armed;

endmodule
`default_nettype wire

// File: rtl/frame_rate_divider.sv
`default_nettype none
// ============================================================================
// Module   : frame_rate_divider -- CHANNELS independent frame-rate dividers
// Revision : 1.0
// ============================================================================
module frame_rate_divider
  import frame_pkg::*;
#(
  parameter int WIDTH    = FRAME_W,
  parameter int CHANNELS = FRAME_CHANNELS
) (
  input  wire logic            clk,
  input  wire logic            resetn,
  frame_rate_divider_if.slave  bus
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam int c_lo = chan_lo(i, WIDTH);

    frame_div_channel #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk       (clk),
      .resetn    (resetn),
      .i_enable  (bus.enable),
      .i_speed   (bus.speed[c_lo +: WIDTH]),
      .i_oneshot (bus.oneshot[i]),
      .i_restart (bus.restart[i]),
      .o_tick    (bus.tick[i]),
      .o_count   (bus.count[c_lo +: WIDTH]),
      .o_armed   (bus.armed[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_rate_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_rate_divider -- directed and random checks vs frame model
// Revision : 1.0
// ============================================================================
module tb_frame_rate_divider;

  localparam int W  = 4;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  frame_rate_divider_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  frame_rate_divider #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference: frames seen since the channel was (re)armed or last fired.
  int frames [CH];
  bit live   [CH];
  bit fired  [CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      frames[c] = 0;
      live[c]   = 1'b1;
      fired[c]  = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      int target;
      target   = int'(bus.speed[c*W +: W]);
      fired[c] = 1'b0;
      if (bus.restart[c]) begin
        frames[c] = 0;
        live[c]   = 1'b1;
      end else if (live[c] && bus.enable) begin
        if (frames[c] >= target) begin
          frames[c] = 0;
          fired[c]  = 1'b1;
          if (bus.oneshot[c]) live[c] = 1'b0;
        end else begin
          frames[c] = frames[c] + 1;
        end
      end
    end
  endfunction

  task automatic check(input string tag);
    logic [CH-1:0]   exp_tick;
    logic [CH*W-1:0] exp_count;
    logic [CH-1:0]   exp_armed;
    for (int c = 0; c < CH; c++) begin
      exp_tick[c]          = fired[c];
      exp_armed[c]         = live[c];
      exp_count[c*W +: W]  = W'(frames[c]);
    end
    vectors++;
    assert (bus.tick === exp_tick) else begin
      miscompares++;
      $error("FAIL %s tick observed=%b expected=%b", tag, bus.tick, exp_tick);
    end
    vectors++;
    assert (bus.count === exp_count) else begin
      miscompares++;
      $error("FAIL %s count observed=%h expected=%h", tag, bus.count, exp_count);
    end
    vectors++;
    assert (bus.armed === exp_armed) else begin
      miscompares++;
      $error("FAIL %s armed observed=%b expected=%b", tag, bus.armed, exp_armed);
    end
  endtask

  task automatic check_const(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (resetn) model_step();
    else        model_reset();
    #1;
    check(tag);
  endtask

  task automatic set_speed(input int c, input int v);
    bus.speed[c*W +: W] = v[W-1:0];
  endtask

  task automatic restart_all();
    bus.restart = '1;
    cycle("restart");
    bus.restart = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak;
    int guard;

    resetn      = 1'b0;
    bus.enable  = 1'b0;
    bus.speed   = '0;
    bus.oneshot = '0;
    bus.restart = '0;
    model_reset();
    cycle("reset");
    cycle("reset");
    check_const("reset_armed", 32'(bus.armed), 32'hF);
    check_const("reset_tick", 32'(bus.tick), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Periodic: speed0=3, enable every 4 cycles.
    set_speed(0, 3); set_speed(1, 0); set_speed(2, 1); set_speed(3, 2);
    for (int k = 0; k < 64; k++) begin
      bus.enable = (k % 4 == 0);
      cycle("periodic");
    end
    bus.enable = 1'b0;

    // Four channels at speeds 0..3, enable every cycle.
    restart_all();
    set_speed(0, 0); set_speed(1, 1); set_speed(2, 2); set_speed(3, 3);
    bus.enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cycle("multi");
      if (k == 1) check_const("coincide", 32'(bus.tick[1:0]), 32'h3);
    end
    bus.enable = 1'b0;

    // One-shot on channel 1 with speed 2.
    restart_all();
    set_speed(1, 2);
    bus.oneshot = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      bus.enable = (k % 2 == 0);
      cycle("oneshot");
    end
    check_const("oneshot_disarmed", 32'(bus.armed[1]), 32'h0);
    check_const("oneshot_count", 32'(bus.count[W +: W]), 32'h0);
    bus.restart = 4'b0010;
    bus.enable  = 1'b1;
    cycle("oneshot_rearm");
    bus.restart = '0;
    for (int k = 0; k < 16; k++) begin
      bus.enable = (k % 2 == 0);
      cycle("oneshot2");
    end
    bus.oneshot = '0;

    // Speed lowered below the running count.
    restart_all();
    set_speed(0, 10);
    bus.enable = 1'b1;
    guard = 0;
    while (frames[0] != 7 && guard < 20) begin
      cycle("lower_run");
      guard++;
    end
    set_speed(0, 4);
    cycle("lower_fire");
    check_const("lower_tick", 32'(bus.tick[0]), 32'h1);
    check_const("lower_count", 32'(bus.count[0 +: W]), 32'h0);

    // speed = 0 with enable held: tick every cycle on all channels.
    bus.speed = '0;
    restart_all();
    bus.enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle("speed0");
      check_const("speed0_tick", 32'(bus.tick), 32'hF);
    end

    // speed = max: 16 enables per tick, count peaks at 15.
    bus.speed = '1;
    restart_all();
    bus.enable = 1'b1;
    peak = 0;
    for (int k = 0; k < 40; k++) begin
      cycle("speed_max");
      if (int'(bus.count[0 +: W]) > peak) peak = int'(bus.count[0 +: W]);
    end
    check_const("speed_max_peak", 32'(peak), 32'd15);

    // restart and enable together.
    bus.restart = 4'b0101;
    cycle("collide");
    bus.restart = '0;

    // Asynchronous reset at count=5.
    restart_all();
    guard = 0;
    while (frames[0] != 5 && guard < 20) begin
      cycle("async_run");
      guard++;
    end
    bus.enable = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    check_const("async_count", 32'(bus.count), 32'h0);
    check_const("async_tick", 32'(bus.tick), 32'h0);
    check_const("async_armed", 32'(bus.armed), 32'hF);
    model_reset();
    #1;
    resetn = 1'b1;
    bus.enable = 1'b1;
    cycle("post_reset");
    check_const("post_reset_count", 32'(bus.count[0 +: W]), 32'h1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bus.enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bus.speed = 16'($urandom);
      if ($urandom_range(0, 31) == 0) bus.oneshot = 4'($urandom);
      bus.restart = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_rate_divider.md
# frame_rate_divider

Multi-channel, parametrised frame-rate divider. Each channel counts incoming frame-enable pulses and emits a single-cycle tick every `speed+1` frames. Channels run free (periodic) or fire once and stop (one-shot). The block sits between the VGA frame-enable source and the game/draw FSMs, driving block movement, erase timing and drop timers from one frame source at independent rates.

## Interface
Parameters:
- `WIDTH`, 4: counter and speed width per channel; maximum period is 2^WIDTH frames.
- `CHANNELS`, 2: number of independent divider channels.

Ports:
- `clk`  in  1: system clock.
- `resetn`  in  1: reset, asynchronous and active-low.
- `enable`  in  1: frame-enable pulse, one `clk` cycle per frame; shared by all channels.
- `speed`  in  CHANNELS*WIDTH: per-channel terminal count; channel i uses bits [i*WIDTH +: WIDTH].
- `oneshot`  in  CHANNELS: per-channel mode. 0 = periodic, 1 = one-shot.
- `restart`  in  CHANNELS: synchronous per-channel clear and re-arm.
- `tick`  out  CHANNELS: registered single-cycle pulse per channel.
- `count`  out  CHANNELS*WIDTH: current frame count per channel.
- `armed`  out  CHANNELS: channel is counting; low once a one-shot channel has fired.

## Operation
- Reset state: `count`=0, `tick`=0, `armed`=all ones. Every output is defined out of reset, with no X on `tick`.
- Per-channel priority, evaluated each `clk`:
  1. `restart[i]` → `count`=0, `armed`=1, `tick`=0. Ignores `enable`.
  2. `armed[i]`=0 → hold `count`; `tick`=0.
  3. `enable`=0 → hold `count`; `tick`=0. The tick never sticks high across cycles.
  4. `enable`=1 and `count >= speed[i]` → `count`=0, `tick`=1, and `armed`=0 if `oneshot[i]`.
  5. `enable`=1 otherwise → `count`+1, `tick`=0.
- The comparison is `>=`, not `==`. If `speed` is lowered below the current count, the channel fires on the next enable and never wraps through 2^WIDTH.
- `speed`=0 → tick on every enable.
- `speed`=2^WIDTH−1 → period of 2^WIDTH enables; `count` never overflows.
- `speed` and `oneshot` are sampled live on every enable. There is no shadow register.
- `oneshot` toggled while armed takes effect at the next terminal count.
- Channels are fully independent. Simultaneous ticks on all channels are legal.

## Timing
- Tick latency: `tick[i]` is high in the cycle after the `clk` edge that samples the terminal-count enable, for exactly one cycle.
- Period: with constant `speed`=S and `enable` every N cycles, ticks are spaced (S+1)·N cycles apart.
  - The first tick after reset or `restart` follows the (S+1)th enable.
- `restart` and `enable` in the same cycle: restart wins. That enable is not counted.
- Asynchronous reset mid-count: all outputs clear immediately. The first enable after deassertion counts as frame 0→1.
- Back-to-back enables (every cycle) are legal. Ticks may then occur on consecutive cycles when S=0.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package (`frame_pkg`): `FRAME_W` default, `mode_t` enum (`MODE_PERIODIC`, `MODE_ONESHOT`) and the per-channel slice helper constant.
- Sub-module `frame_div_channel`: one counter, armed flag and tick register, with WIDTH as its parameter.
- The top level instantiates `frame_div_channel` CHANNELS times in a generate loop and only slices and concatenates buses. It holds no logic.

## Test plan
- **Periodic, WIDTH=4, speed0=3, enable every 4 cycles:** `tick[0]` pulses once per 4 enables (every 16 cycles), is high for 1 cycle each time, and `count[0]` cycles through 0,1,2,3,0.
- **One-shot, speed1=2, oneshot1=1:** exactly one tick after the 3rd enable, then `armed[1]`=0 and `count[1]`=0 holds. Pulse `restart[1]` → `armed[1]`=1, and the next tick follows 3 more enables.
- **Speed lowered mid-count:** speed0=10, run to count=7, set speed0=4 → tick on the next enable and count→0, with no wrap to 15.
- **Boundaries:** speed=0 with enable held high → tick every cycle. speed=15 → 16 enables per tick, and `count` peaks at 15.
- **Collisions:** `restart` and `enable` together → count=0, no tick. Assert `resetn`=0 asynchronously mid-count at count=5 → outputs clear before the next `clk` edge, and `armed`=all ones.
- **CHANNELS=4 with speeds 0, 1, 2, 3:** ticks are independent with correct periods. On the enable where channels 0 and 1 coincide, both `tick` bits are high in the same cycle.
